// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider: one quotient bit per clock, MSB first.
// Optional SEQ_DIVIDER_ZERO_FAST_EN: a zero divisor completes without iterating.
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

`ifdef SEQ_DIVIDER_ZERO_FAST_EN
  localparam bit ZERO_FAST = 1'b1;
`else
  localparam bit ZERO_FAST = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvd_q, dvs_q, rem_q, quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, last_step, fast_zero;
  logic [WIDTH:0]   rem_shift, diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next, quo_next;

  always_comb begin
    accept    = start && (state != RUN);
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
    fast_zero = ZERO_FAST && (divisor == '0);
  end

  // One restoring step; a zero divisor naturally yields all-ones quotient
  // and the dividend as remainder, since every difference is non-negative.
  always_comb begin
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    q_bit     = (rem_shift >= {1'b0, dvs_q});
    rem_next  = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start)              state_nxt = fast_zero ? DONE : RUN;
        else if (state == DONE) state_nxt = IDLE;
      end
      RUN:     if (last_step) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      dvd_q <= dividend;
      dvs_q <= divisor;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      if (fast_zero) begin
        quotient  <= '1;
        remainder <= dividend;
        div_zero  <= 1'b1;
      end
    end else if (state == RUN) begin
      dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
      rem_q <= rem_next;
      quo_q <= quo_next;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_step) begin
        quotient  <= quo_next;
        remainder <= rem_next;
        div_zero  <= (dvs_q == '0);
      end
    end
  end

endmodule
